// File: rtl/scan_mux.sv
// scan_mux: registered N-channel, W-bit selector with a direct mode and a scan mode.
//
// Direct mode (mode=0, FSM idle): the addressed channel is loaded into the
// output register whenever the output stage can accept a new beat. Scan mode:
// a start pulse walks channels 0..CHANNELS-1 once, one beat each. The output
// uses a valid/ready handshake.
//
// Optional build macro: SCAN_MUX_PARITY_EN adds out_parity (XOR reduction of out).
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   in_bus       flattened channels, channel k = in_bus[k*WIDTH +: WIDTH]
//   address      channel select in direct mode
//   mode         0 = direct, 1 = scan (sampled only while idle)
//   start        one-cycle pulse, begins a scan when mode=1 and idle
//   out_ready    downstream accepts the beat this cycle
//   out          registered selected data
//   out_parity   (SCAN_MUX_PARITY_EN only) even parity of out
//   out_valid    out/out_channel hold a beat
//   out_channel  index of the channel in out
//   busy         FSM not idle
//   scan_done    one-cycle pulse after the last scan beat is accepted
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | direct sampling (mode=0) or draining, waiting for start (mode=1)
// SCAN  | loading channels in order, then waiting for the last beat to go
// DONE  | one cycle, scan_done asserted

module scan_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]          address,
    input  logic                      mode,
    input  logic                      start,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out,
`ifdef SCAN_MUX_PARITY_EN
    output logic                      out_parity,
`endif
    output logic                      out_valid,
    output logic [SEL_W-1:0]          out_channel,
    output logic                      busy,
    output logic                      scan_done
);

    // One extra counter bit so "all channels loaded" is representable even
    // when CHANNELS == 2**SEL_W.
    localparam int               CNT_W   = SEL_W + 1;
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(CHANNELS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               valid_q, valid_d;
    logic [SEL_W-1:0]   ch_q, ch_d;

    logic               load_ok;
    logic               accept;
    logic               load;
    logic [SEL_W-1:0]   load_idx;

    // Out-of-range indices match no channel and therefore select zero.
    function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] bus,
                                              input logic [SEL_W-1:0]          idx);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx == SEL_W'(k)) begin
                v = bus[k*WIDTH +: WIDTH];
            end
        end
        return v;
    endfunction

    assign load_ok = !valid_q || out_ready;
    assign accept  = valid_q && out_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        valid_d  = valid_q;
        ch_d     = ch_q;
        load     = 1'b0;
        load_idx = address;

        case (state_q)
            ST_IDLE: begin
                if (!mode) begin
                    load     = load_ok;
                    load_idx = address;
                end else begin
                    if (accept) begin
                        valid_d = 1'b0;
                    end
                    if (start) begin
                        state_d = ST_SCAN;
                        cnt_d   = '0;
                    end
                end
            end
            ST_SCAN: begin
                // A pending direct beat simply blocks load_ok until taken.
                if (cnt_q == CNT_END) begin
                    if (accept) begin
                        valid_d = 1'b0;
                        state_d = ST_DONE;
                    end
                end else if (load_ok) begin
                    load     = 1'b1;
                    load_idx = cnt_q[SEL_W-1:0];
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            out_d   = pick(in_bus, load_idx);
            ch_d    = load_idx;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ch_q    <= ch_d;
        end
    end

`ifdef SCAN_MUX_PARITY_EN
    logic parity_q, parity_d;

    // out_d equals out_q when nothing loads, so this also holds under stall.
    always_comb begin
        parity_d = ^out_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign out_parity = parity_q;
`endif

    assign out         = out_q;
    assign out_valid   = valid_q;
    assign out_channel = ch_q;
    assign busy        = (state_q != ST_IDLE);
    assign scan_done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_scan_mux.sv
// Bench for scan_mux: a 4-channel and a 3-channel instance driven in lockstep,
// compared every cycle against a behavioural model, plus scoreboards of the
// beats accepted during scans.

module tb_scan_mux;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] bus;
    logic [1:0]  addr;
    logic        mode, start, rdy;

    logic [7:0]  o4, o3;
    logic        v4, v3, b4, b3, d4, d3;
    logic [1:0]  c4, c3;
`ifdef SCAN_MUX_PARITY_EN
    logic        p4, p3;
`endif

    always #5 clk = ~clk;

    scan_mux #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_bus(bus), .address(addr),
        .mode(mode), .start(start), .out_ready(rdy), .out(o4),
`ifdef SCAN_MUX_PARITY_EN
        .out_parity(p4),
`endif
        .out_valid(v4), .out_channel(c4), .busy(b4), .scan_done(d4)
    );

    scan_mux #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut3 (
        .clk(clk), .reset_n(reset_n), .in_bus(bus[23:0]), .address(addr),
        .mode(mode), .start(start), .out_ready(rdy), .out(o3),
`ifdef SCAN_MUX_PARITY_EN
        .out_parity(p3),
`endif
        .out_valid(v3), .out_channel(c3), .busy(b3), .scan_done(d3)
    );

    // phase: 0 idle, 1 scanning, 2 done cycle; next_ch: next scan channel to load
    typedef struct {
        logic [7:0] out;
        logic       valid;
        int         ch;
        int         phase;
        int         next_ch;
    } mdl_t;

    mdl_t m4, m3;
    int   n_pass = 0;
    int   n_total = 0;
    int   q4[$];
    int   q3[$];
    int   done4 = 0;
    int   done3 = 0;

    function automatic logic [7:0] chan_val(logic [31:0] b, int nch, int a);
        if (a < nch) return 8'((b >> (a * 8)) & 32'hFF);
        return 8'h00;
    endfunction

    function automatic mdl_t mreset();
        mdl_t n;
        n.out = 8'h00; n.valid = 1'b0; n.ch = 0; n.phase = 0; n.next_ch = 0;
        return n;
    endfunction

    function automatic mdl_t mload(mdl_t m, logic [31:0] b, int nch, int a);
        mdl_t n = m;
        n.out = chan_val(b, nch, a);
        n.ch = a;
        n.valid = 1'b1;
        return n;
    endfunction

    function automatic mdl_t mstep(mdl_t m, int nch, logic [31:0] b, int a,
                                   logic md, logic st, logic rd);
        mdl_t n = m;
        bit room = !m.valid || rd;
        bit taken = m.valid && rd;
        case (m.phase)
            0: begin
                if (!md) begin
                    if (room) n = mload(m, b, nch, a);
                end else begin
                    if (taken) n.valid = 1'b0;
                    if (st) begin n.phase = 1; n.next_ch = 0; end
                end
            end
            1: begin
                if (m.next_ch < nch) begin
                    if (room) begin
                        n = mload(m, b, nch, m.next_ch);
                        n.next_ch = m.next_ch + 1;
                    end
                end else if (taken) begin
                    n.valid = 1'b0;
                    n.phase = 2;
                end
            end
            default: n.phase = 0;
        endcase
        return n;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_outputs();
        chk("out4",   32'(o4), 32'(m4.out));
        chk("valid4", 32'(v4), 32'(m4.valid));
        chk("ch4",    32'(c4), 32'(m4.ch));
        chk("busy4",  32'(b4), 32'(m4.phase != 0));
        chk("done4",  32'(d4), 32'(m4.phase == 2));
        chk("out3",   32'(o3), 32'(m3.out));
        chk("valid3", 32'(v3), 32'(m3.valid));
        chk("ch3",    32'(c3), 32'(m3.ch));
        chk("busy3",  32'(b3), 32'(m3.phase != 0));
        chk("done3",  32'(d3), 32'(m3.phase == 2));
`ifdef SCAN_MUX_PARITY_EN
        chk("par4",   32'(p4), 32'(^m4.out));
        chk("par3",   32'(p3), 32'(^m3.out));
`endif
    endtask

    // One clock: log accepted scan beats seen on the DUT before the edge,
    // advance the model at the edge, compare just after it.
    task automatic tick();
        if (v4 && rdy && b4) q4.push_back(int'(c4) * 256 + int'(o4));
        if (v3 && rdy && b3) q3.push_back(int'(c3) * 256 + int'(o3));
        @(posedge clk);
        m4 = mstep(m4, 4, bus, int'(addr), mode, start, rdy);
        m3 = mstep(m3, 3, bus, int'(addr), mode, start, rdy);
        #1;
        check_outputs();
        if (d4) done4++;
        if (d3) done3++;
    endtask

    // Reset asserted mid-cycle, held across one edge, released mid-cycle.
    task automatic async_reset();
        #3;
        reset_n = 1'b0;
        bus = $urandom; addr = 2'($urandom); rdy = 1'($urandom);
        #1;
        m4 = mreset(); m3 = mreset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        #3;
        reset_n = 1'b1;
    endtask

    task automatic clear_sb();
        q4.delete(); q3.delete();
        done4 = 0; done3 = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1;
        bus = $urandom; addr = 2'($urandom); mode = 1'($urandom);
        start = 1'b0; rdy = 1'b1;
        m4 = mreset(); m3 = mreset();
        #2;
        async_reset();

        // direct mode loads on the first edge after release
        mode = 1'b0; rdy = 1'b1; addr = 2'($urandom); bus = $urandom;
        tick();

        // directed select
        bus = 32'h44332211; addr = 2'd2;
        tick();
        chk("dir_a2_out4", 32'(o4), 32'h33);
        chk("dir_a2_ch4",  32'(c4), 32'd2);
`ifdef SCAN_MUX_PARITY_EN
        chk("par_33", 32'(p3), 32'd0);
`endif
        addr = 2'd3;
        tick();
        chk("dir_a3_out4", 32'(o4), 32'h44);
        chk("oor_out3",    32'(o3), 32'h00);
        chk("oor_ch3",     32'(c3), 32'd3);
        chk("oor_valid3",  32'(v3), 32'd1);

        // stall: output frozen while inputs move
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            addr = 2'($urandom); bus = $urandom;
            tick();
            chk("stall_out4", 32'(o4), 32'h44);
            chk("stall_ch4",  32'(c4), 32'd3);
        end
        rdy = 1'b1;
        tick();
        chk("unstall_out4", 32'(o4), 32'(chan_val(bus, 4, int'(addr))));

        bus = 32'h00000013; addr = 2'd0;
        tick();
`ifdef SCAN_MUX_PARITY_EN
        chk("par_13", 32'(p3), 32'd1);
`endif

        // full scan, no backpressure
        clear_sb();
        bus = 32'h44332211; mode = 1'b1; start = 1'b1; rdy = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("scan4_count", 32'(q4.size()), 32'd4);
        for (int k = 0; k < q4.size() && k < 4; k++)
            chk("scan4_beat", 32'(q4[k]), 32'(k * 256 + (k + 1) * 17));
        chk("scan3_count", 32'(q3.size()), 32'd3);
        for (int k = 0; k < q3.size() && k < 3; k++)
            chk("scan3_beat", 32'(q3[k]), 32'(k * 256 + (k + 1) * 17));
        chk("scan4_done_pulses", 32'(done4), 32'd1);
        chk("scan3_done_pulses", 32'(done3), 32'd1);
        chk("scan4_busy_end", 32'(b4), 32'd0);

        // scan with toggling ready, extra start, mode flips, moving data
        clear_sb();
        mode = 1'b1; start = 1'b1; rdy = 1'b1;
        tick();
        for (int i = 0; i < 30; i++) begin
            rdy = (i % 2 == 0);
            start = (i == 2);
            mode = 1'($urandom);
            bus = $urandom;
            tick();
        end
        start = 1'b0;
        chk("bp4_count", 32'(q4.size()), 32'd4);
        for (int k = 0; k < q4.size() && k < 4; k++)
            chk("bp4_order", 32'(q4[k] / 256), 32'(k));
        chk("bp3_count", 32'(q3.size()), 32'd3);
        for (int k = 0; k < q3.size() && k < 3; k++)
            chk("bp3_order", 32'(q3[k] / 256), 32'(k));
        chk("bp4_done_pulses", 32'(done4), 32'd1);

        // reset while beat 2 is presented
        mode = 1'b0; rdy = 1'b1;
        tick();
        clear_sb();
        mode = 1'b1; start = 1'b1; bus = $urandom;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("abort_ch4_before", 32'(c4), 32'd1);
        async_reset();
        mode = 1'b0; rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            addr = 2'($urandom); bus = $urandom;
            tick();
        end
        chk("abort_no_done4", 32'(done4), 32'd0);
        chk("abort_no_done3", 32'(done3), 32'd0);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            bus = $urandom;
            addr = 2'($urandom);
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            start = ($urandom_range(0, 5) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            if (i == 150) async_reset();
            tick();
        end
        start = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/scan_mux.md
Name: scan_mux

Overview:
- Parametrised, registered N-channel, W-bit selector; the next generation of the team's 4:1 single-bit multiplexer.
- Two modes:
  - Direct mode: one addressed channel per beat.
  - Scan mode: an FSM walks all channels in order after a start pulse.
- Output uses a valid/ready handshake, so the block drops straight into streamed datapaths (sampling front-ends, debug readout).

Parameters:
- WIDTH, 8, bit width of each input channel and of the output
- CHANNELS, 4, number of input channels (2..64, need not be a power of two)
- SEL_W, 2, width of address and channel index; SEL_W >= clog2(CHANNELS)

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_bus  input  CHANNELS*WIDTH  flattened channel inputs; channel k = in_bus[k*WIDTH +: WIDTH]
- address  input  SEL_W  channel select in direct mode
- mode  input  1  0 = direct, 1 = scan
- start  input  1  one-cycle pulse; begins a scan when mode=1 and FSM is IDLE
- out_ready  input  1  downstream accepts the beat this cycle
- out  output  WIDTH  registered selected data
- out_valid  output  1  out/out_channel hold a beat
- out_channel  output  SEL_W  index of the channel in out
- busy  output  1  FSM not IDLE
- scan_done  output  1  one-cycle pulse after the last scan beat is accepted

Behaviour:
- Reset (reset_n low, asynchronous): out=0, out_valid=0, out_channel=0, busy=0, scan_done=0, FSM=IDLE, scan counter=0.
- Output stage can load when out_valid==0 or out_ready==1 ("load_ok").
- Beat acceptance occurs when out_valid && out_ready.
- Direct mode (mode=0, FSM IDLE):
  - Each load_ok cycle: out <= channel[address], out_channel <= address, out_valid <= 1.
  - Latency 1 clock.
  - out_valid stays 1 continuously (free-running sampler).
- Stall: while out_valid && !out_ready, out and out_channel hold, even if address or in_bus change.
- Out-of-range address (address >= CHANNELS): out <= 0, out_channel <= address, out_valid <= 1. Never X.
- Scan FSM states: IDLE, SCAN, DONE.
  - IDLE -> SCAN on start && mode==1; scan counter <= 0; busy=1 from the next cycle.
  - In SCAN, on load_ok: out <= channel[counter], out_channel <= counter, out_valid <= 1, counter increments.
  - After channel CHANNELS-1 is loaded, no further loads occur. out_valid clears on acceptance of that last beat.
  - SCAN -> DONE when the last beat (out_channel==CHANNELS-1) is accepted. scan_done=1 for exactly the DONE cycle.
  - DONE -> IDLE unconditionally.
- Scan-mode IDLE: out_valid clears on acceptance and no new loads occur.
- Ignored inputs:
  - start while busy is ignored.
  - start with mode==0 is ignored.
- mode change during SCAN is ignored until the FSM returns to IDLE. mode is sampled only in IDLE.
- Transition from direct to scan: a pending direct-mode beat must be accepted before the first scan beat is loaded (normal load_ok rule).
- Scan data is sampled at load time, not at start.
- Asynchronous reset mid-scan aborts immediately to reset values. No scan_done is issued.

Optional Feature:
- Macro: SCAN_MUX_PARITY_EN.
- When defined:
  - Adds output port out_parity (1 bit) = even parity (XOR reduction) of out, registered with out.
  - Resets to 0 and holds under stall like out.
- When undefined: the port and its logic are absent.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: assert reset_n=0 mid-cycle with random inputs -> out=0, out_valid=0, busy=0 immediately; release -> direct mode starts loading on the first edge.
- Direct select: WIDTH=8, CHANNELS=4, channels {0x11,0x22,0x33,0x44}, address=2, out_ready=1 -> next cycle out=0x33, out_channel=2, out_valid=1; address=3 -> out=0x44 one cycle later.
- Stall: out_ready=0 for 3 cycles while address toggles and in_bus changes -> out/out_channel frozen; out_ready=1 -> new value loaded the following cycle.
- Full scan: mode=1, start pulse, out_ready=1 -> beats 0x11,0x22,0x33,0x44 on 4 consecutive cycles with out_channel 0..3, then scan_done=1 for one cycle, busy falls.
- Scan with backpressure and bad requests:
  - out_ready toggles 1,0,1,0 -> each channel is emitted exactly once, in order.
  - Extra start mid-scan -> ignored.
  - Reset during beat 2 -> no scan_done.
- Non-power-of-two: CHANNELS=3, SEL_W=2, direct address=3 -> out=0, out_channel=3; scan emits exactly 3 beats. With SCAN_MUX_PARITY_EN, out=0x33 -> out_parity=0 and out=0x13 -> out_parity=1.
